seg7_decoder: RTL and testbench



---
 rtl/seg7_decoder.sv | 44 ++++
 tb/tb_seg7_decoder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/seg7_decoder.sv
// Registered BCD-to-7-segment decoder for one active-low (common-anode) HEX digit.
// Output bit order is {g,f,e,d,c,b,a}; invalid codes 10-15 blank the display.
module seg7_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] bcd,
  output logic [6:0] out
);

  localparam int unsigned SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  logic [SEG_W-1:0] seg_d;
  logic [SEG_W-1:0] seg_q;

  // Digit decode; anything outside 0-9 (including X/Z) falls through to blank.
  always_comb begin
    seg_d = SEG_BLANK;
    case (bcd)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= SEG_BLANK;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign out = seg_q;

endmodule

// File: tb/tb_seg7_decoder.sv
// Self-checking bench for seg7_decoder: directed cases plus random stimulus
// compared against a segment-name reference model.
module tb_seg7_decoder;

  logic       clk;
  logic       reset;
  logic [3:0] bcd;
  logic [6:0] out;

  int n_checks;
  int n_pass;
  logic [6:0] prev_exp;
  logic       have_prev;
  string      lit_segs [10];

  seg7_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bcd   (bcd),
    .out   (out)
  );

  always #5 clk = ~clk;

  // Reference: list the lit segments by name, then drive those bits low.
  function automatic logic [6:0] ref_seg(input logic [3:0] b, input logic rst);
    logic [6:0] v;
    string s;
    v = 7'h7F;
    if (!rst && b < 4'd10) begin
      s = lit_segs[int'(b)];
      for (int i = 0; i < s.len(); i++) begin
        v[int'(s[i]) - int'("a")] = 1'b0;
      end
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: out=%b expected=%b", tag, got, exp);
    end
  endtask

  // Apply inputs, confirm output holds until the edge, then check the new value.
  task automatic step(input string tag, input logic [3:0] b, input logic rst);
    logic [6:0] exp;
    reset = rst;
    bcd   = b;
    #1;
    if (have_prev) check({tag, "_hold"}, out, prev_exp);
    @(posedge clk);
    #1;
    exp = ref_seg(b, rst);
    check(tag, out, exp);
    prev_exp  = exp;
    have_prev = 1'b1;
  endtask

  initial begin
    lit_segs[0] = "abcdef";
    lit_segs[1] = "bc";
    lit_segs[2] = "abdeg";
    lit_segs[3] = "abcdg";
    lit_segs[4] = "bcfg";
    lit_segs[5] = "acdfg";
    lit_segs[6] = "acdefg";
    lit_segs[7] = "abc";
    lit_segs[8] = "abcdefg";
    lit_segs[9] = "abcdfg";

    clk       = 1'b0;
    reset     = 1'b1;
    bcd       = 4'd8;
    n_checks  = 0;
    n_pass    = 0;
    prev_exp  = 7'h7F;
    have_prev = 1'b0;

    @(posedge clk);
    #1;

    // Reset with bcd=8 held for two edges, then release.
    step("reset0", 4'd8, 1'b1);
    step("reset1", 4'd8, 1'b1);
    check("reset_const", out, 7'b1111111);
    step("release", 4'd8, 1'b0);
    check("release_const", out, 7'b0000000);

    // Full sweep including invalid codes.
    for (int i = 0; i < 16; i++) begin
      step($sformatf("sweep_%0d", i), 4'(i), 1'b0);
    end

    // Counter-display use case.
    step("cnt_2", 4'd2, 1'b0);
    check("cnt_2_const", out, 7'b0100100);
    step("cnt_5", 4'd5, 1'b0);
    check("cnt_5_const", out, 7'b0010010);
    step("cnt_0", 4'd0, 1'b0);
    check("cnt_0_const", out, 7'b1000000);

    // Mid-stream single-cycle reset.
    step("mid_a", 4'd3, 1'b0);
    check("mid_a_const", out, 7'b0110000);
    step("mid_rst", 4'd3, 1'b1);
    check("mid_rst_const", out, 7'b1111111);
    step("mid_b", 4'd3, 1'b0);
    check("mid_b_const", out, 7'b0110000);

    // Back-to-back toggling 1 <-> 8.
    for (int i = 0; i < 6; i++) begin
      step($sformatf("toggle_%0d", i), (i % 2 == 0) ? 4'd1 : 4'd8, 1'b0);
    end

    // Random stimulus with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      step($sformatf("rand_%0d", i), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
